// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch counting rising edges of a slow divider output in the system clock domain.
// Optional lap-hold display capture is built when LAP_EN is defined.
module stopwatch_core #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTick_in,
  input  logic       iStartStop,
  input  logic       iClear,
`ifdef LAP_EN
  input  logic       iLap,
`endif
  output logic [3:0] oSecOnes,
  output logic [3:0] oSecTens,
  output logic [3:0] oMinOnes,
  output logic [3:0] oMinTens,
  output logic [1:0] oState,
  output logic       oRollover
`ifdef LAP_EN
  ,
  output logic       oLapHold
`endif
);

  localparam logic [3:0] MaxTens = 4'(MIN_MAX / 10);
  localparam logic [3:0] MaxOnes = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } digits_t;

  logic       tick_sync1_q, tick_sync2_q, tick_hist_q;
  logic [1:0] tick_prime_q;
  logic       tick_armed_q, tick_armed_d;
  logic       tick;

  logic       start_hist_q, start_pulse_q;
  logic       clear_hist_q, clear_pulse_q;

  state_e     state_q, state_d;
  digits_t    cnt_q, cnt_d;
  logic       rollover_q, rollover_d;

  // A tick is only honoured once the synchronized input has been observed low after
  // reset, so a level that is already high at release does not count as an edge.
  assign tick_armed_d = tick_armed_q | (tick_prime_q[1] & ~tick_sync2_q);
  assign tick         = tick_sync2_q & ~tick_hist_q & tick_armed_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tick_sync1_q  <= 1'b0;
      tick_sync2_q  <= 1'b0;
      tick_hist_q   <= 1'b0;
      tick_prime_q  <= 2'b00;
      tick_armed_q  <= 1'b0;
      start_hist_q  <= 1'b0;
      start_pulse_q <= 1'b0;
      clear_hist_q  <= 1'b0;
      clear_pulse_q <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      rollover_q    <= 1'b0;
    end else begin
      tick_sync1_q  <= iTick_in;
      tick_sync2_q  <= tick_sync1_q;
      tick_hist_q   <= tick_sync2_q;
      tick_prime_q  <= {tick_prime_q[0], 1'b1};
      tick_armed_q  <= tick_armed_d;
      start_hist_q  <= iStartStop;
      start_pulse_q <= iStartStop & ~start_hist_q;
      clear_hist_q  <= iClear;
      clear_pulse_q <= iClear & ~clear_hist_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rollover_q    <= rollover_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rollover_d = 1'b0;
    if (clear_pulse_q) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      // A tick coinciding with a stop press in RUN is still counted.
      if (state_q == StRun && tick) begin
        if (cnt_q.sec_ones != 4'd9) begin
          cnt_d.sec_ones = cnt_q.sec_ones + 4'd1;
        end else begin
          cnt_d.sec_ones = 4'd0;
          if (cnt_q.sec_tens != 4'd5) begin
            cnt_d.sec_tens = cnt_q.sec_tens + 4'd1;
          end else begin
            cnt_d.sec_tens = 4'd0;
            if (cnt_q.min_tens == MaxTens && cnt_q.min_ones == MaxOnes) begin
              cnt_d.min_tens = 4'd0;
              cnt_d.min_ones = 4'd0;
              rollover_d     = 1'b1;
            end else if (cnt_q.min_ones != 4'd9) begin
              cnt_d.min_ones = cnt_q.min_ones + 4'd1;
            end else begin
              cnt_d.min_ones = 4'd0;
              cnt_d.min_tens = cnt_q.min_tens + 4'd1;
            end
          end
        end
      end
      if (start_pulse_q) begin
        unique case (state_q)
          StIdle:  state_d = StRun;
          StRun:   state_d = StPause;
          StPause: state_d = StRun;
          default: state_d = StIdle;
        endcase
      end
    end
  end

`ifdef LAP_EN
  logic    lap_hist_q, lap_pulse_q;
  logic    lap_hold_q, lap_hold_d;
  digits_t lap_q, lap_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      lap_hist_q  <= 1'b0;
      lap_pulse_q <= 1'b0;
      lap_hold_q  <= 1'b0;
      lap_q       <= '0;
    end else begin
      lap_hist_q  <= iLap;
      lap_pulse_q <= iLap & ~lap_hist_q;
      lap_hold_q  <= lap_hold_d;
      lap_q       <= lap_d;
    end
  end

  // Any exit from RUN (stop or clear) drops the hold at the same edge.
  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (state_d != StRun || clear_pulse_q) begin
      lap_hold_d = 1'b0;
    end else if (lap_pulse_q && state_q == StRun) begin
      if (!lap_hold_q) begin
        lap_hold_d = 1'b1;
        lap_d      = cnt_q;
      end else begin
        lap_hold_d = 1'b0;
      end
    end
  end

  digits_t disp;
  assign disp     = lap_hold_q ? lap_q : cnt_q;
  assign oLapHold = lap_hold_q;
`else
  digits_t disp;
  assign disp = cnt_q;
`endif

  assign oSecOnes  = disp.sec_ones;
  assign oSecTens  = disp.sec_tens;
  assign oMinOnes  = disp.min_ones;
  assign oMinTens  = disp.min_tens;
  assign oState    = state_q;
  assign oRollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core built with MIN_MAX=2 so the wrap is reachable quickly.
// Lap-hold vectors run only when LAP_EN is defined.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [1:0] state;
  logic       rollover;
`ifdef LAP_EN
  logic       lap;
  logic       lap_hold;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_core #(
    .MIN_MAX(2)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iTick_in   (tick_in),
    .iStartStop (start_stop),
    .iClear     (clear),
`ifdef LAP_EN
    .iLap       (lap),
`endif
    .oSecOnes   (sec_ones),
    .oSecTens   (sec_tens),
    .oMinOnes   (min_ones),
    .oMinTens   (min_tens),
    .oState     (state),
    .oRollover  (rollover)
`ifdef LAP_EN
    ,
    .oLapHold   (lap_hold)
`endif
  );

  logic [15:0] digits;
  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising clock edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic one_tick();
    tick_in = 1'b1;
    step(2);
    tick_in = 1'b0;
    step(2);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) one_tick();
  endtask

  task automatic press_start();
    start_stop = 1'b1;
    step(2);
    start_stop = 1'b0;
    step(1);
  endtask

`ifdef LAP_EN
  task automatic press_lap();
    lap = 1'b1;
    step(2);
    lap = 1'b0;
    step(1);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    tick_in    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
`ifdef LAP_EN
    lap        = 1'b0;
`endif
    step(2);
    check_val("reset_digits", digits, 16'h0000);
    check_val("reset_state", {14'd0, state}, 16'd0);
    check_val("reset_rollover", {15'd0, rollover}, 16'd0);
    rst = 1'b0;
    step(4);

    press_start();
    check_val("start_state", {14'd0, state}, 16'd1);

    // Increment lands on the third edge after the rising input is first sampled.
    tick_in = 1'b1;
    step(2);
    check_val("latency_before", digits, 16'h0000);
    step(1);
    check_val("latency_at", digits, 16'h0001);
    tick_in = 1'b0;
    step(2);
    run_ticks(4);
    check_val("five_ticks", digits, 16'h0005);
    check_val("run_state", {14'd0, state}, 16'd1);

    run_ticks(2);
    press_start();
    check_val("pause_state", {14'd0, state}, 16'd2);
    run_ticks(3);
    check_val("pause_hold", digits, 16'h0007);
    press_start();
    run_ticks(1);
    check_val("resume_count", digits, 16'h0008);

    // Tick and stop edge in the same cycle while running.
    run_ticks(2);
    tick_in = 1'b1;
    step(1);
    start_stop = 1'b1;
    step(2);
    check_val("tick_stop_digits", digits, 16'h0011);
    check_val("tick_stop_state", {14'd0, state}, 16'd2);
    start_stop = 1'b0;
    tick_in    = 1'b0;
    step(2);

    press_start();
    run_ticks(48);
    check_val("at_0059", digits, 16'h0059);
    run_ticks(1);
    check_val("minute_carry", digits, 16'h0100);
    run_ticks(23);
    check_val("at_0123", digits, 16'h0123);

    // Reset mid-count with the divider input high.
    tick_in = 1'b1;
    step(1);
    rst = 1'b1;
    #1;
    check_val("midrst_digits", digits, 16'h0000);
    check_val("midrst_state", {14'd0, state}, 16'd0);
    check_val("midrst_rollover", {15'd0, rollover}, 16'd0);
    step(1);
    rst = 1'b0;
    step(3);
    press_start();
    step(4);
    check_val("no_tick_high_release", digits, 16'h0000);
    tick_in = 1'b0;
    step(3);
    tick_in = 1'b1;
    step(3);
    check_val("first_tick_after_low", digits, 16'h0001);
    tick_in = 1'b0;
    step(2);

    run_ticks(178);
    check_val("at_0259", digits, 16'h0259);
    tick_in = 1'b1;
    step(3);
    check_val("wrap_digits", digits, 16'h0000);
    check_val("wrap_pulse", {15'd0, rollover}, 16'd1);
    check_val("wrap_state", {14'd0, state}, 16'd1);
    tick_in = 1'b0;
    step(1);
    check_val("wrap_pulse_end", {15'd0, rollover}, 16'd0);
    step(1);

    // Clear and tick in the same cycle.
    run_ticks(30);
    check_val("at_0030", digits, 16'h0030);
    tick_in = 1'b1;
    step(1);
    clear = 1'b1;
    step(2);
    check_val("clear_tick_digits", digits, 16'h0000);
    check_val("clear_tick_state", {14'd0, state}, 16'd0);
    clear   = 1'b0;
    tick_in = 1'b0;
    step(2);

`ifdef LAP_EN
    press_start();
    run_ticks(4);
    press_lap();
    check_val("lap_hold_on", {15'd0, lap_hold}, 16'd1);
    run_ticks(3);
    check_val("lap_frozen", digits, 16'h0004);
    press_lap();
    check_val("lap_live", digits, 16'h0007);
    check_val("lap_hold_off", {15'd0, lap_hold}, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch counter that consumes the slow square wave from the clock divider and keeps an MM:SS count in BCD for the display stage. It synchronizes the divider output into the system clock domain and converts each rising edge into a one-cycle count enable. Start/stop/clear controls come from debounced push-buttons. All logic runs on the single 1 MHz system clock; the divided signal is never used as a clock.

## Interface
- MIN_MAX, 59: minute value at which the minute count wraps to 0; binary, legal range 1..99.
- iClk  input  1  system clock, 1 MHz, rising-edge active.
- iRst  input  1  reset, asynchronous, active-high.
- iTick_in  input  1  divided clock from the clock divider, nominal 1 Hz, asynchronous to iClk.
- iStartStop  input  1  debounced level, synchronous to iClk; a rising edge is a press.
- iClear  input  1  debounced level, synchronous to iClk; a rising edge is a press.
- iLap  input  1  debounced level, synchronous to iClk; present only with LAP_EN.
- oSecOnes  output  4  BCD seconds ones digit, 0..9.
- oSecTens  output  4  BCD seconds tens digit, 0..5.
- oMinOnes  output  4  BCD minutes ones digit.
- oMinTens  output  4  BCD minutes tens digit.
- oState  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
- oRollover  output  1  one-cycle pulse when the count wraps from MIN_MAX:59 to 00:00.
- oLapHold  output  1  lap hold active; present only with LAP_EN.

## Operation
- iTick_in passes through a 2-FF synchronizer, then a history register. tick = sync2 & ~hist, asserted for exactly one iClk cycle per rising edge of iTick_in.
- iStartStop, iClear and iLap each use one history register for edge detection. No synchronizer is applied to them.
- FSM:
  - IDLE: start edge -> RUN.
  - RUN: start edge -> PAUSE.
  - PAUSE: start edge -> RUN.
  - Clear edge in any state -> IDLE with all digits reset to 0.
- Counting happens only in RUN on tick:
  - Seconds ones count 0..9, then carry into seconds tens (0..5).
  - A carry out of 59 increments minutes; minutes wrap to 00 after MIN_MAX.
  - MIN_MAX is compared against the BCD minute pair.
- Wrap MIN_MAX:59 -> 00:00: oRollover pulses once and the FSM stays in RUN.
- Priority within one cycle: clear > start/stop > tick.
- Tick and start edge in the same cycle:
  - In RUN, the tick is counted, and the state moves to PAUSE at the same edge.
  - In IDLE or PAUSE, the tick is ignored.
- Tick and clear in the same cycle: the tick is discarded and the count becomes 00:00.
- Reset (asserted at any time, including mid-count): all outputs 0, state IDLE, synchronizer and history registers 0. A high iTick_in at release therefore produces a tick only if it is seen low first.

## Timing
- A rising iTick_in sampled at edge N gives tick high during the cycle after edge N+1. The digits update at edge N+2.
- Button edge sampled at edge N: history updates at N, the edge is seen in the cycle after N, and the state/digits change at edge N+1.
- oRollover is high for the single cycle following the wrap edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Minimum iTick_in high and low times: 2 iClk cycles each. Shorter pulses may be lost.

## Configuration
- LAP_EN defined:
  - The iLap and oLapHold ports exist.
  - A rising edge of iLap in RUN toggles lap hold. On entry, the current digits are captured into a display register.
  - While held, the digit outputs show the captured value and the internal count keeps advancing.
  - A second iLap edge releases the hold, and the outputs show the live count at the next edge.
  - Clear, reset, or leaving RUN via stop releases the hold. The hold releases at the same edge.
  - An iLap edge in IDLE or PAUSE is ignored.
- LAP_EN undefined: neither port exists, and the digit outputs are always the live count.

## Test plan
- Reset, start press, 5 iTick_in periods -> digits 00:05, oState=01; each increment lands 3 iClk edges after the iTick_in rising edge.
- Run to 00:59, one tick -> 01:00; set MIN_MAX=2, run to 02:59, one tick -> 00:00, oRollover high exactly 1 cycle, oState stays 01.
- Stop press at 00:07, 3 ticks -> digits hold 00:07, oState=10; start again, 1 tick -> 00:08.
- Clear and tick in the same cycle at 00:30 -> 00:00, oState=00; tick and stop in the same cycle in RUN at 00:10 -> 00:11, oState=10.
- iRst pulsed mid-count at 01:23 while iTick_in is high -> all outputs 0 immediately; no tick until iTick_in goes low, then high.
- LAP_EN: lap at 00:04, 3 ticks -> outputs 00:04 with oLapHold=1; lap again -> outputs 00:07, oLapHold=0.
